// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles SYNC/OP/ADDR/DATA/CHK frames from the UART byte stream
// into register-bus writes and reads, and returns read data to the UART transmitter.
module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic       cmd_wr,
  output logic       cmd_rd,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_wdata,
  input  logic       cmd_rd_ack,
  input  logic [7:0] cmd_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [3:0] {
    S_SYNC, S_OP, S_ADDR, S_DAT, S_CHK, S_WR, S_RD, S_RWAIT, S_TX
  } state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_op, r_addr, r_data, r_tx, r_err;
  logic [TW-1:0] r_tmo;
  logic          w_in_frame, w_acc, w_tmo, w_chk_ok, w_err;
  assign w_in_frame    = r_state inside {S_OP, S_ADDR, S_DAT, S_CHK};
  assign rx_data_ready = w_in_frame || (r_state == S_SYNC);
  assign w_acc         = rx_data_valid && rx_data_ready;
  // an accepted byte on the same edge always beats the timeout
  assign w_tmo         = w_in_frame && !w_acc && (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_chk_ok      = rx_data == (r_op ^ r_addr ^ r_data);
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      S_SYNC:  w_next = (w_acc && rx_data == SYNC_BYTE) ? S_OP : S_SYNC;
      S_OP:    w_next = w_acc ? S_ADDR : S_OP;
      S_ADDR:  w_next = w_acc ? S_DAT : S_ADDR;
      S_DAT:   w_next = w_acc ? S_CHK : S_DAT;
      S_CHK: begin
        if (w_acc) begin
          w_next = (w_chk_ok && r_op == 8'h01) ? S_WR :
                   (w_chk_ok && r_op == 8'h02) ? S_RD : S_SYNC;
          w_err  = !(w_chk_ok && (r_op == 8'h01 || r_op == 8'h02));
        end
      end
      S_WR:    w_next = S_SYNC;
      S_RD:    w_next = S_RWAIT;
      S_RWAIT: w_next = cmd_rd_ack ? S_TX : S_RWAIT;
      S_TX:    w_next = tx_ready ? S_SYNC : S_TX;
      default: w_next = S_SYNC;
    endcase
    if (w_tmo) begin
      w_next = S_SYNC;
      w_err  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SYNC;
      r_tmo   <= '0;
      r_op    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_tx    <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_next;
      r_tmo   <= (w_acc || !w_in_frame) ? '0 : r_tmo + TW'(1);
      if (w_acc && r_state == S_OP) r_op <= rx_data;
      if (w_acc && r_state == S_ADDR) r_addr <= rx_data;
      if (w_acc && r_state == S_DAT) r_data <= rx_data;
      if (r_state == S_RWAIT && cmd_rd_ack) r_tx <= cmd_rdata;
      if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end
  assign cmd_wr    = r_state == S_WR;
  assign cmd_rd    = r_state == S_RD;
  assign cmd_addr  = r_addr;
  assign cmd_wdata = r_data;
  assign tx_data   = r_tx;
  assign tx_valid  = r_state == S_TX;
  assign err_cnt   = r_err;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed and randomized frame traffic checked against a frame-level model.
module tb_uart_cmd_decoder;
  localparam int T = 40;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic       rx_data_ready, cmd_wr, cmd_rd, tx_valid;
  logic [7:0] cmd_addr, cmd_wdata, tx_data, err_cnt;
  logic       cmd_rd_ack, tx_ready;
  logic [7:0] cmd_rdata;
  int         n_tot = 0, n_bad = 0, m_err = 0, lat = 0;
  bit         m_in = 1'b0, man = 1'b1;
  logic [7:0] m_buf[$], exp_rd[$], exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [15:0] w_e;
  logic [7:0] mem[256];
  logic [7:0] rd_a = 8'h00, man_rdata = 8'h00;
  logic       man_ack = 1'b0, man_txr = 1'b0;

  uart_cmd_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .cmd_wr(cmd_wr), .cmd_rd(cmd_rd), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_rd_ack(cmd_rd_ack), .cmd_rdata(cmd_rdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_bump();
    m_err = (m_err < 255) ? m_err + 1 : 255;
  endfunction

  // frame-level reference: g idle cycles before a byte means accept-to-accept distance g+1
  function automatic void model_byte(input logic [7:0] b, input int g);
    if (m_in && g >= T) begin
      m_bump();
      m_in = 1'b0;
    end
    if (!m_in) begin
      if (b == 8'hA5) begin
        m_in = 1'b1;
        m_buf.delete();
      end
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == 4) begin
        m_in = 1'b0;
        if (m_buf[3] != (m_buf[0] ^ m_buf[1] ^ m_buf[2]) || !(m_buf[0] == 8'h01 || m_buf[0] == 8'h02))
          m_bump();
        else if (m_buf[0] == 8'h01)
          exp_wr.push_back({m_buf[1], m_buf[2]});
        else begin
          exp_rd.push_back(m_buf[1]);
          exp_tx.push_back(mem[m_buf[1]]);
        end
      end
    end
  endfunction

  function automatic int rgap();
    int r;
    r = int'($urandom % 10);
    return (r == 0) ? T - 1 : (r == 1) ? T : r % 4;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int g);
    int k;
    model_byte(b, g);
    repeat (g) @(negedge clk);
    rx_data = b;
    rx_data_valid = 1'b1;
    k = 0;
    while (!rx_data_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k == 2000) check("rx_stall", 0, 1);
    @(posedge clk);
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4, input bit rnd);
    send_byte(b0, rnd ? rgap() : 0);
    send_byte(b1, rnd ? rgap() : 0);
    send_byte(b2, rnd ? rgap() : 0);
    send_byte(b3, rnd ? rgap() : 0);
    send_byte(b4, rnd ? rgap() : 0);
  endtask

  task automatic settle();
    repeat (T + 10) @(negedge clk);
    if (m_in) begin
      m_bump();
      m_in = 1'b0;
    end
    check("err_cnt", err_cnt, m_err);
    check("wr_left", exp_wr.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    check("tx_left", exp_tx.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr"}, cmd_wr, 0);
    check({tag, "_rd"}, cmd_rd, 0);
    check({tag, "_addr"}, cmd_addr, 0);
    check({tag, "_wdata"}, cmd_wdata, 0);
    check({tag, "_txv"}, tx_valid, 0);
    check({tag, "_txd"}, tx_data, 0);
    check({tag, "_err"}, err_cnt, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    rx_data_valid = 1'b0;
    #1 check_zero("rst");
    m_err = 0;
    m_in = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    exp_tx.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // bus responder, TX sink and strobe monitors
  always @(negedge clk) begin
    if (man) begin
      cmd_rd_ack = man_ack;
      cmd_rdata  = man_rdata;
      tx_ready   = man_txr;
    end else begin
      cmd_rd_ack = 1'b0;
      cmd_rdata  = 8'($urandom);
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          cmd_rd_ack = 1'b1;
          cmd_rdata  = mem[rd_a];
        end
      end
      tx_ready = ($urandom % 4) != 0;
    end
    if (cmd_rd && !man) begin
      lat  = int'($urandom_range(1, 4));
      rd_a = cmd_addr;
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) check("tx_extra", 1, 0);
      else check("tx_data", tx_data, exp_tx.pop_front());
    end
    if (cmd_wr) begin
      if (exp_wr.size() == 0) check("wr_extra", 1, 0);
      else begin
        w_e = exp_wr.pop_front();
        check("wr_addr", cmd_addr, w_e[15:8]);
        check("wr_data", cmd_wdata, w_e[7:0]);
      end
    end
    if (cmd_rd) begin
      if (exp_rd.size() == 0) check("rd_extra", 1, 0);
      else check("rd_addr", cmd_addr, exp_rd.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] op, a, d, c;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h20] = 8'h5A;
    #1 check_zero("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    // single write, strobe one cycle after CHK
    man = 1'b0;
    send5(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D, 1'b0);
    check("wr_lat", cmd_wr, 1);
    check("wr_addr_d", cmd_addr, 8'h10);
    check("wr_data_d", cmd_wdata, 8'h3C);
    @(negedge clk);
    check("wr_pulse", cmd_wr, 0);
    settle();
    // read with ack three cycles after the strobe and a slow transmitter
    man = 1'b1;
    send5(8'hA5, 8'h02, 8'h20, 8'h00, 8'h22, 1'b0);
    check("rd_lat", cmd_rd, 1);
    repeat (2) @(posedge clk);
    #1 man_ack = 1'b1;
    man_rdata = 8'h5A;
    @(posedge clk);
    #1 man_ack = 1'b0;
    @(negedge clk);
    check("tx_valid_on", tx_valid, 1);
    check("tx_data_d", tx_data, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tx_hold", tx_valid, 1);
    end
    @(posedge clk);
    #1 man_txr = 1'b1;
    @(posedge clk);
    #1 man_txr = 1'b0;
    @(negedge clk);
    check("tx_valid_off", tx_valid, 0);
    man = 1'b0;
    settle();
    // bad checksum, then a good write
    send5(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00, 1'b0);
    check("badchk_nowr", cmd_wr, 0);
    check("badchk_err", err_cnt, m_err);
    send5(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D, 1'b0);
    check("after_bad_wr", cmd_wr, 1);
    settle();
    // garbage ahead of a frame is dropped silently
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send5(8'hA5, 8'h01, 8'h11, 8'h22, 8'h32, 1'b0);
    check("garb_wr", cmd_wr, 1);
    check("garb_addr", cmd_addr, 8'h11);
    check("garb_err", err_cnt, m_err);
    settle();
    // timeout on silence, then boundary gaps T-1 (ok) and T (expires)
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    settle();
    send_byte(8'hA5, 0);
    send_byte(8'h01, T - 1);
    send_byte(8'h10, T);
    send5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27, 1'b0);
    check("tmo_wr", cmd_wr, 1);
    settle();
    // randomized frame mix with random gaps
    for (int f = 0; f < 40; f++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      case ($urandom % 5)
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h01 + 8'($urandom % 2);
        3: op = 8'h03 + 8'($urandom % 250);
        default: op = 8'h00;
      endcase
      c = op ^ a ^ d;
      if (op == 8'h00) send_byte(8'($urandom), rgap());
      else begin
        if (($urandom % 5) == 0) c = c ^ 8'h01;
        send5(8'hA5, op, a, d, c, 1'b1);
      end
    end
    settle();
    // saturation of the error counter
    for (int i = 0; i < 260; i++) send5(8'hA5, 8'h07, 8'h00, 8'h00, 8'h07, 1'b0);
    check("err_sat", err_cnt, 8'hFF);
    check("err_sat_m", err_cnt, m_err);
    // reset with a response pending on the transmitter
    man = 1'b1;
    send5(8'hA5, 8'h02, 8'h30, 8'h00, 8'h32, 1'b0);
    check("rd2_lat", cmd_rd, 1);
    @(posedge clk);
    #1 man_ack = 1'b1;
    man_rdata = mem[8'h30];
    @(posedge clk);
    #1 man_ack = 1'b0;
    @(negedge clk);
    check("rd2_txv", tx_valid, 1);
    do_reset();
    // reset mid-frame
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    do_reset();
    man = 1'b0;
    send5(8'hA5, 8'h01, 8'h44, 8'h55, 8'h10, 1'b0);
    check("post_rst_wr", cmd_wr, 1);
    settle();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
